wb_stage: RTL and testbench

- Write-back producer for the ARM pipeline register file. Drives its write port signals writeBackEn, Dest_wb and Result_wb.
- Merges two result sources into at most one register write per cycle:
  - single-cycle ALU results;
  - variable-latency memory load responses.
- Buffers collisions in a small FIFO and exports a pending-destination vector for hazard detection.
- Exports stall and ld_busy for upstream flow control.

---
 rtl/wb_stage_pkg.sv | 8 +
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/wb_stage.sv | 198 +++++++++++++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared register-file dimensions for the write-back path
package wb_stage_pkg;

    localparam int REGISTER_LEN        = 32;  // data width
    localparam int REGFILE_ADDRESS_LEN = 4;   // register index width
    localparam int REGISTER_MEM_SIZE   = 16;  // architectural registers

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - collision buffer for write-back items, two pushes and one pop per cycle
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   push0_*/push1_*                 ordered pushes; push1 is only used together with push0
//   pop_i                           retire head entry
//   head_valid_o/dest_o/data_o      oldest entry
//   count_o                         occupied entries
//   valid_o/dest_o                  per-slot occupancy and destination, for hazard tracking
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0_i,
    input  logic [AW-1:0]                push0_dest_i,
    input  logic [DW-1:0]                push0_data_i,
    input  logic                         push1_i,
    input  logic [AW-1:0]                push1_dest_i,
    input  logic [DW-1:0]                push1_data_i,
    input  logic                         pop_i,
    output logic                         head_valid_o,
    output logic [AW-1:0]                head_dest_o,
    output logic [DW-1:0]                head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][AW-1:0]     dest_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] dest_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push0_i) begin
                dest_q[wr_q] <= push0_dest_i;
                data_q[wr_q] <= push0_data_i;
            end
            if (push1_i) begin
                dest_q[ptr_inc(wr_q)] <= push1_dest_i;
                data_q[ptr_inc(wr_q)] <= push1_data_i;
            end
            if (push1_i)      wr_q <= ptr_inc(ptr_inc(wr_q));
            else if (push0_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)        rd_q <= ptr_inc(rd_q);
            count_q <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_dest_o  = dest_q[rd_q];
    assign head_data_o  = data_q[rd_q];
    assign count_o      = count_q;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = (((i >= int'(rd_q)) ? (i - int'(rd_q)) : (i + DEPTH - int'(rd_q)))
                          < int'(count_q));
            dest_o[i]  = dest_q[i];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - merges ALU results and load responses into one register-file write per cycle
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   alu_valid/alu_dest/alu_result          single-cycle ALU result
//   ld_req/ld_dest                         load issue, reserves destination
//   mem_rsp_valid/mem_rsp_data             load data return
//   writeBackEn/Dest_wb/Result_wb          registered register-file write port
//   pending                                registers with an outstanding write
//   stall, ld_busy                         upstream flow control
//   err                                    sticky protocol-violation flag
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_valid,
    input  logic [REGFILE_ADDRESS_LEN-1:0] alu_dest,
    input  logic [REGISTER_LEN-1:0]        alu_result,
    input  logic                           ld_req,
    input  logic [REGFILE_ADDRESS_LEN-1:0] ld_dest,
    input  logic                           mem_rsp_valid,
    input  logic [REGISTER_LEN-1:0]        mem_rsp_data,
    output logic                           writeBackEn,
    output logic [REGFILE_ADDRESS_LEN-1:0] Dest_wb,
    output logic [REGISTER_LEN-1:0]        Result_wb,
    output logic [REGISTER_MEM_SIZE-1:0]   pending,
    output logic                           stall,
    output logic                           ld_busy,
    output logic                           err
);

    localparam int AW = REGFILE_ADDRESS_LEN;
    localparam int DW = REGISTER_LEN;
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {LD_IDLE = 1'b0, LD_WAIT = 1'b1} ld_state_e;

    ld_state_e      ld_state_q, ld_state_d;
    logic [AW-1:0]  ld_dest_q, ld_dest_d;
    logic           wb_en_q, wb_en_d;
    logic [AW-1:0]  wb_dest_q, wb_dest_d;
    logic [DW-1:0]  wb_res_q, wb_res_d;
    logic           err_q, err_d;

    logic                      fifo_head_valid;
    logic [AW-1:0]             fifo_head_dest;
    logic [DW-1:0]             fifo_head_data;
    logic [CW-1:0]             fifo_count;
    logic [DEPTH-1:0]          fifo_valid;
    logic [DEPTH-1:0][AW-1:0]  fifo_dest;
    logic                      push0, push1, pop;
    logic [AW-1:0]             push0_dest, push1_dest;
    logic [DW-1:0]             push0_data, push1_data;

    logic                      rsp_acc;
    logic                      drop;
    logic [2:0]                it_v;
    logic [AW-1:0]             it_dest [3];
    logic [DW-1:0]             it_data [3];

    assign rsp_acc = mem_rsp_valid && (ld_state_q == LD_WAIT);

    // Load FSM: a response and a new request in the same WAIT cycle chain directly.
    always_comb begin
        ld_state_d = ld_state_q;
        ld_dest_d  = ld_dest_q;
        case (ld_state_q)
            LD_IDLE: if (ld_req) begin
                ld_state_d = LD_WAIT;
                ld_dest_d  = ld_dest;
            end
            LD_WAIT: if (mem_rsp_valid) begin
                if (ld_req) ld_dest_d = ld_dest;
                else        ld_state_d = LD_IDLE;
            end
            default: ld_state_d = LD_IDLE;
        endcase
    end

    // Candidates in age order: FIFO head, load response, ALU.
    always_comb begin
        it_v       = {alu_valid, rsp_acc, fifo_head_valid};
        it_dest[0] = fifo_head_dest;
        it_data[0] = fifo_head_data;
        it_dest[1] = ld_dest_q;
        it_data[1] = mem_rsp_data;
        it_dest[2] = alu_dest;
        it_data[2] = alu_result;
    end

    // The oldest candidate goes to the output register; the rest queue in
    // order until free space runs out, and anything beyond that is dropped.
    always_comb begin
        int  space;
        int  npush;
        logic taken;
        space      = DEPTH - int'(fifo_count) + (fifo_head_valid ? 1 : 0);
        npush      = 0;
        taken      = 1'b0;
        drop       = 1'b0;
        pop        = 1'b0;
        push0      = 1'b0;
        push1      = 1'b0;
        push0_dest = '0;
        push0_data = '0;
        push1_dest = '0;
        push1_data = '0;
        wb_en_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_res_d   = wb_res_q;
        for (int i = 0; i < 3; i++) begin
            if (it_v[i]) begin
                if (!taken) begin
                    taken     = 1'b1;
                    wb_en_d   = 1'b1;
                    wb_dest_d = it_dest[i];
                    wb_res_d  = it_data[i];
                    if (i == 0) pop = 1'b1;
                end else if (npush < space) begin
                    if (npush == 0) begin
                        push0      = 1'b1;
                        push0_dest = it_dest[i];
                        push0_data = it_data[i];
                    end else begin
                        push1      = 1'b1;
                        push1_dest = it_dest[i];
                        push1_data = it_data[i];
                    end
                    npush = npush + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        err_d = err_q | drop
              | (mem_rsp_valid && (ld_state_q == LD_IDLE))
              | (ld_req && (ld_state_q == LD_WAIT) && !mem_rsp_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state_q <= LD_IDLE;
            ld_dest_q  <= '0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_res_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            ld_dest_q  <= ld_dest_d;
            wb_en_q    <= wb_en_d;
            wb_dest_q  <= wb_dest_d;
            wb_res_q   <= wb_res_d;
            err_q      <= err_d;
        end
    end

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (push0),
        .push0_dest_i (push0_dest),
        .push0_data_i (push0_data),
        .push1_i      (push1),
        .push1_dest_i (push1_dest),
        .push1_data_i (push1_data),
        .pop_i        (pop),
        .head_valid_o (fifo_head_valid),
        .head_dest_o  (fifo_head_dest),
        .head_data_o  (fifo_head_data),
        .count_o      (fifo_count),
        .valid_o      (fifo_valid),
        .dest_o       (fifo_dest)
    );

    always_comb begin
        pending = '0;
        if (ld_state_q == LD_WAIT) pending[ld_dest_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) pending[fifo_dest[i]] = 1'b1;
        end
        if (wb_en_q) pending[wb_dest_q] = 1'b1;
    end

    assign stall       = (int'(fifo_count) >= DEPTH - 1);
    assign ld_busy     = (ld_state_q == LD_WAIT);
    assign writeBackEn = wb_en_q;
    assign Dest_wb     = wb_dest_q;
    assign Result_wb   = wb_res_q;
    assign err         = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized and directed bench for wb_stage against a queue model
module tb_wb_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_dest = '0;
    logic [31:0] alu_result = '0;
    logic        ld_req = 1'b0;
    logic [3:0]  ld_dest = '0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic [15:0] pending;
    logic        stall;
    logic        ld_busy;
    logic        err;

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_dest      (alu_dest),
        .alu_result    (alu_result),
        .ld_req        (ld_req),
        .ld_dest       (ld_dest),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .writeBackEn   (writeBackEn),
        .Dest_wb       (Dest_wb),
        .Result_wb     (Result_wb),
        .pending       (pending),
        .stall         (stall),
        .ld_busy       (ld_busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } item_t;

    item_t       m_q[$];
    logic        m_busy = 1'b0;
    logic [3:0]  m_ldd = '0;
    logic        m_en = 1'b0;
    logic [3:0]  m_dest = '0;
    logic [31:0] m_res = '0;
    logic        m_err = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Everything outstanding is a list in age order; the head retires each
    // cycle and whatever exceeds the buffer depth is lost.
    task automatic model_step();
        item_t it;
        logic  old_busy;
        logic [3:0] old_ldd;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_ldd = 0; m_en = 0; m_dest = 0; m_res = 0; m_err = 0;
            return;
        end
        old_busy = m_busy;
        old_ldd  = m_ldd;
        if (mem_rsp_valid && !old_busy) m_err = 1;
        if (ld_req && old_busy && !mem_rsp_valid) m_err = 1;
        if (mem_rsp_valid && old_busy) m_q.push_back('{old_ldd, mem_rsp_data});
        if (alu_valid) m_q.push_back('{alu_dest, alu_result});
        if (ld_req && (!old_busy || mem_rsp_valid)) begin
            m_busy = 1; m_ldd = ld_dest;
        end else if (mem_rsp_valid && old_busy) begin
            m_busy = 0;
        end
        if (m_q.size() > 0) begin
            it = m_q.pop_front();
            m_en = 1; m_dest = it.d; m_res = it.v;
        end else begin
            m_en = 0;
        end
        while (m_q.size() > DEPTH) begin
            void'(m_q.pop_back());
            m_err = 1;
        end
    endtask

    function automatic logic [15:0] model_pending();
        logic [15:0] p = '0;
        if (m_busy) p[m_ldd] = 1'b1;
        foreach (m_q[i]) p[m_q[i].d] = 1'b1;
        if (m_en) p[m_dest] = 1'b1;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("wen", 64'(writeBackEn), 64'(m_en));
        check("dest", 64'(Dest_wb), 64'(m_dest));
        check("res", 64'(Result_wb), 64'(m_res));
        check("pending", 64'(pending), 64'(model_pending()));
        check("stall", 64'(stall), 64'(m_q.size() >= DEPTH - 1));
        check("busy", 64'(ld_busy), 64'(m_busy));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic step(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] ar,
                        input logic lq, input logic [3:0] ld, input logic mv, input logic [31:0] md);
        rst = r; alu_valid = av; alu_dest = ad; alu_result = ar;
        ld_req = lq; ld_dest = ld; mem_rsp_valid = mv; mem_rsp_data = md;
        tick();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic mstall;
        // reset then single ALU op
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_wen", 64'(writeBackEn), 64'd0);
        step(0, 1, 4'd3, 32'h1234, 0, 0, 0, 0);
        check("alu_dest", 64'(Dest_wb), 64'd3);
        check("alu_res", 64'(Result_wb), 64'h1234);
        idle();
        check("alu_once", 64'(writeBackEn), 64'd0);
        check("alu_pend3", 64'(pending[3]), 64'd0);

        // load round trip
        step(0, 0, 0, 0, 1, 4'd7, 0, 0);
        repeat (4) begin
            idle();
            check("ld_pend7", 64'(pending[7]), 64'd1);
        end
        step(0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
        check("ld_dest", 64'(Dest_wb), 64'd7);
        check("ld_res", 64'(Result_wb), 64'hCAFE);
        idle();
        check("ld_pend_clr", 64'(pending[7]), 64'd0);

        // collision
        step(0, 0, 0, 0, 1, 4'd7, 0, 0);
        step(0, 1, 4'd2, 32'h55, 0, 0, 1, 32'hCAFE);
        check("col_first", 64'(Dest_wb), 64'd7);
        check("col_stall", 64'(stall), 64'd1);
        idle();
        check("col_second", 64'(Dest_wb), 64'd2);
        check("col_res2", 64'(Result_wb), 64'h55);
        idle();

        // protocol errors
        step(0, 0, 0, 0, 1, 4'd8, 0, 0);
        step(0, 0, 0, 0, 1, 4'd9, 0, 0);
        check("perr_ld", 64'(err), 64'd1);
        step(0, 0, 0, 0, 0, 0, 1, 32'hBEEF);
        check("perr_dest", 64'(Dest_wb), 64'd8);
        step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        check("perr_nowr", 64'(writeBackEn), 64'd0);
        idle();

        // reset mid-operation
        step(0, 0, 0, 0, 1, 4'd5, 0, 0);
        step(0, 1, 4'd6, 32'h66, 1, 4'd10, 1, 32'h55AA);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("mid_pending", 64'(pending), 64'd0);
        check("mid_wen", 64'(writeBackEn), 64'd0);
        repeat (3) idle();

        // same-register chain
        step(0, 1, 4'd4, 32'h1, 0, 0, 0, 0);
        step(0, 1, 4'd4, 32'h2, 0, 0, 0, 0);
        step(0, 1, 4'd4, 32'h3, 0, 0, 0, 0);
        check("chain_last", 64'(Result_wb), 64'h3);
        check("chain_pend", 64'(pending[4]), 64'd1);
        idle();
        check("chain_clr", 64'(pending[4]), 64'd0);

        // randomized traffic, mostly honouring stall
        for (int n = 0; n < 600; n++) begin
            mstall = (m_q.size() >= DEPTH - 1);
            rst = ($urandom_range(0, 59) == 0);
            alu_valid = ($urandom_range(0, 2) != 0) && (!mstall || $urandom_range(0, 19) == 0);
            alu_dest = 4'($urandom_range(0, 15));
            alu_result = $urandom;
            ld_req = ($urandom_range(0, 3) == 0) && (!mstall || $urandom_range(0, 19) == 0);
            ld_dest = 4'($urandom_range(0, 15));
            mem_rsp_valid = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            mem_rsp_data = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
